// File: rtl/fp32_pkg.sv
// Shared binary32 field widths, special encodings and the add/sub FSM state type.
package fp32_pkg;

  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int BIAS  = 127;

  localparam logic [31:0] QNAN    = 32'h7FC00000;
  localparam logic [31:0] POS_INF = 32'h7F800000;
  localparam logic [31:0] NEG_INF = 32'hFF800000;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ALIGN = 3'd1,
    ADD   = 3'd2,
    NORM  = 3'd3,
    ROUND = 3'd4,
    WB    = 3'd5
  } state_e;

endpackage

// File: rtl/fp_lzc28.sv
// Combinational leading-zero counter for the 28-bit raw sum (returns 28 for an all-zero input).
module fp_lzc28 (
  input  logic [27:0] in_val,
  output logic [4:0]  lzc
);

  // Scan upward so the highest set bit writes last and wins
  always_comb begin
    lzc = 5'd28;
    for (int i = 0; i < 28; i++) begin
      lzc = in_val[i] ? 5'(27 - i) : lzc;
    end
  end

endmodule

// File: rtl/fp_addsub_unit.sv
// Multi-cycle binary32 add/subtract (RNE, flush-to-zero) writing its result into the register memory.
// Optional build macro FP_STATUS_FLAGS_EN adds flags[3:0] = {invalid, overflow, underflow, inexact}.
module fp_addsub_unit
  import fp32_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              op_sub,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  input  logic [ADDR_W-1:0] dst_addr,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data
`ifdef FP_STATUS_FLAGS_EN
  ,
  output logic [3:0]        flags
`endif
);

  state_e              state_q, state_d;
  logic                in_ready_q, in_ready_d;
  logic                wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;
  logic [31:0]         a_q, a_d, b_q, b_d;
  logic                sub_q, sub_d;
  logic [ADDR_W-1:0]   dst_q, dst_d;
  logic                sign_q, sign_d;
  logic [9:0]          exp_q, exp_d;
  logic [27:0]         work_q, work_d;
  logic [26:0]         mb_q, mb_d;
  logic                eff_sub_q, eff_sub_d;
  logic                spec_q, spec_d;
  logic [31:0]         spec_val_q, spec_val_d;
`ifdef FP_STATUS_FLAGS_EN
  logic [3:0]          flg_q, flg_d;
  logic [3:0]          flags_q, flags_d;
`endif

  logic [7:0]  a_exp, b_exp, exp_diff;
  logic        a_sgn, b_sgn, a_nan, b_nan, a_inf, b_inf, swap, big_sgn;
  logic [30:0] a_mag, b_mag, big_mag, sml_mag;
  logic [23:0] big_sig, sml_sig;
  logic [4:0]  shamt;
  logic [26:0] sml_field, sml_shr, mb_align;
  logic        sml_lost, spec_hit;
  logic [31:0] spec_word;

  logic [4:0]  lzc, nshift;
  logic [26:0] norm_mant;
  logic [9:0]  norm_exp;
  logic        norm_zero, norm_uflow;

  logic        round_up, round_ovf;
  logic [24:0] round_sig;
  logic [9:0]  round_exp;
  logic [22:0] round_man;
  logic [31:0] round_word;

  // Unpack, classify specials, order by magnitude and align the smaller operand
  always_comb begin
    a_exp     = a_q[30:23];
    b_exp     = b_q[30:23];
    a_sgn     = a_q[31];
    b_sgn     = b_q[31] ^ sub_q;
    a_nan     = (a_exp == 8'hFF) && (a_q[22:0] != 23'd0);
    b_nan     = (b_exp == 8'hFF) && (b_q[22:0] != 23'd0);
    a_inf     = (a_exp == 8'hFF) && (a_q[22:0] == 23'd0);
    b_inf     = (b_exp == 8'hFF) && (b_q[22:0] == 23'd0);
    a_mag     = (a_exp == 8'd0) ? 31'd0 : a_q[30:0];
    b_mag     = (b_exp == 8'd0) ? 31'd0 : b_q[30:0];
    swap      = b_mag > a_mag;
    big_mag   = swap ? b_mag : a_mag;
    sml_mag   = swap ? a_mag : b_mag;
    big_sgn   = swap ? b_sgn : a_sgn;
    big_sig   = (big_mag[30:23] == 8'd0) ? 24'd0 : {1'b1, big_mag[22:0]};
    sml_sig   = (sml_mag[30:23] == 8'd0) ? 24'd0 : {1'b1, sml_mag[22:0]};
    exp_diff  = big_mag[30:23] - sml_mag[30:23];
    shamt     = (exp_diff > 8'd26) ? 5'd26 : exp_diff[4:0];
    sml_field = {sml_sig, 3'b000};
    sml_shr   = sml_field >> shamt;
    sml_lost  = |(sml_field & ((27'd1 << shamt) - 27'd1));
    mb_align  = {sml_shr[26:1], sml_shr[0] | sml_lost};
    if (a_nan || b_nan || (a_inf && b_inf && (a_sgn != b_sgn))) begin
      spec_hit  = 1'b1;
      spec_word = QNAN;
    end else if (a_inf) begin
      spec_hit  = 1'b1;
      spec_word = a_sgn ? NEG_INF : POS_INF;
    end else if (b_inf) begin
      spec_hit  = 1'b1;
      spec_word = b_sgn ? NEG_INF : POS_INF;
    end else begin
      spec_hit  = 1'b0;
      spec_word = 32'd0;
    end
  end

  fp_lzc28 u_lzc (
    .in_val (work_q),
    .lzc    (lzc)
  );

  // Normalise the raw sum so bit 26 holds the hidden one; bit 27 is always clear below the carry
  always_comb begin
    nshift = lzc - 5'd1;
    if (work_q[27]) begin
      norm_mant = {work_q[27:2], work_q[1] | work_q[0]};
      norm_exp  = exp_q + 10'd1;
    end else begin
      norm_mant = work_q[26:0] << nshift;
      norm_exp  = exp_q - {5'd0, nshift};
    end
    norm_zero  = (work_q == 28'd0);
    norm_uflow = norm_exp[9] || (norm_exp == 10'd0);
  end

  // Round to nearest even on G/R/S and saturate to infinity on exponent overflow
  always_comb begin
    round_up  = work_q[2] & (work_q[1] | work_q[0] | work_q[3]);
    round_sig = {1'b0, work_q[26:3]} + {24'd0, round_up};
    if (round_sig[24]) begin
      round_exp = exp_q + 10'd1;
      round_man = round_sig[23:1];
    end else begin
      round_exp = exp_q;
      round_man = round_sig[22:0];
    end
    round_ovf  = (round_exp >= 10'd255);
    round_word = round_ovf ? (sign_q ? NEG_INF : POS_INF) : {sign_q, round_exp[7:0], round_man};
  end

  // Next-state and datapath update, one stage per FSM state
  always_comb begin
    state_d    = state_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    a_d        = a_q;
    b_d        = b_q;
    sub_d      = sub_q;
    dst_d      = dst_q;
    sign_d     = sign_q;
    exp_d      = exp_q;
    work_d     = work_q;
    mb_d       = mb_q;
    eff_sub_d  = eff_sub_q;
    spec_d     = spec_q;
    spec_val_d = spec_val_q;
`ifdef FP_STATUS_FLAGS_EN
    flg_d      = flg_q;
    flags_d    = 4'd0;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = op_a;
          b_d     = op_b;
          sub_d   = op_sub;
          dst_d   = dst_addr;
          state_d = ALIGN;
        end else begin
          state_d = IDLE;
        end
      end
      ALIGN: begin
        sign_d     = big_sgn;
        exp_d      = {2'b00, big_mag[30:23]};
        work_d     = {1'b0, big_sig, 3'b000};
        mb_d       = mb_align;
        eff_sub_d  = a_sgn ^ b_sgn;
        spec_d     = spec_hit;
        spec_val_d = spec_word;
`ifdef FP_STATUS_FLAGS_EN
        flg_d      = {spec_hit && (spec_word == QNAN), 3'b000};
`endif
        state_d    = ADD;
      end
      ADD: begin
        work_d  = eff_sub_q ? (work_q - {1'b0, mb_q}) : (work_q + {1'b0, mb_q});
        state_d = NORM;
      end
      NORM: begin
        if (spec_q) begin
          spec_d = 1'b1;
        end else if (norm_zero) begin
          spec_d     = 1'b1;
          spec_val_d = {sign_q & ~eff_sub_q, 31'd0};
        end else if (norm_uflow) begin
          spec_d     = 1'b1;
          spec_val_d = {sign_q, 31'd0};
`ifdef FP_STATUS_FLAGS_EN
          flg_d[1:0] = 2'b11;
`endif
        end else begin
          work_d = {1'b0, norm_mant};
          exp_d  = norm_exp;
        end
        state_d = ROUND;
      end
      ROUND: begin
        wr_en_d   = 1'b1;
        wr_addr_d = dst_q;
        wr_data_d = spec_q ? spec_val_q : round_word;
`ifdef FP_STATUS_FLAGS_EN
        flags_d   = spec_q ? flg_q
                           : {flg_q[3], round_ovf, flg_q[1], flg_q[0] | round_ovf | (|work_q[2:0])};
`endif
        state_d   = WB;
      end
      WB: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    in_ready_d = (state_d == IDLE);
  end

  // State and datapath registers; synchronous active-low reset abandons any operation
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      in_ready_q <= 1'b1;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= {ADDR_W{1'b0}};
      wr_data_q  <= {DATA_W{1'b0}};
      a_q        <= 32'd0;
      b_q        <= 32'd0;
      sub_q      <= 1'b0;
      dst_q      <= {ADDR_W{1'b0}};
      sign_q     <= 1'b0;
      exp_q      <= 10'd0;
      work_q     <= 28'd0;
      mb_q       <= 27'd0;
      eff_sub_q  <= 1'b0;
      spec_q     <= 1'b0;
      spec_val_q <= 32'd0;
`ifdef FP_STATUS_FLAGS_EN
      flg_q      <= 4'd0;
      flags_q    <= 4'd0;
`endif
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      a_q        <= a_d;
      b_q        <= b_d;
      sub_q      <= sub_d;
      dst_q      <= dst_d;
      sign_q     <= sign_d;
      exp_q      <= exp_d;
      work_q     <= work_d;
      mb_q       <= mb_d;
      eff_sub_q  <= eff_sub_d;
      spec_q     <= spec_d;
      spec_val_q <= spec_val_d;
`ifdef FP_STATUS_FLAGS_EN
      flg_q      <= flg_d;
      flags_q    <= flags_d;
`endif
    end
  end

  assign in_ready = in_ready_q;
  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
`ifdef FP_STATUS_FLAGS_EN
  assign flags    = flags_q;
`endif

endmodule
